// File: rtl/axil_periph_arbiter.sv
// axil_periph_arbiter: NUM_M-master to 1-slave AXI4-Lite arbiter, one txn in flight.
// Optional macro AXIL_ARB_FIXED_PRIO_EN: strict priority (M0 highest) instead of round-robin.
module axil_periph_arbiter #(
  parameter int NUM_M = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_M*32-1:0] m_araddr,
  input  logic [NUM_M*32-1:0] m_awaddr,
  input  logic [NUM_M*32-1:0] m_wdata,
  input  logic [NUM_M*4-1:0]  m_wstrb,
  input  logic [NUM_M-1:0]    m_arvalid,
  input  logic [NUM_M-1:0]    m_awvalid,
  input  logic [NUM_M-1:0]    m_wvalid,
  input  logic [NUM_M-1:0]    m_rready,
  input  logic [NUM_M-1:0]    m_bready,
  output logic [NUM_M-1:0]    m_arready,
  output logic [NUM_M-1:0]    m_awready,
  output logic [NUM_M-1:0]    m_wready,
  output logic [NUM_M-1:0]    m_rvalid,
  output logic [NUM_M-1:0]    m_bvalid,
  output logic [NUM_M*32-1:0] m_rdata,
  output logic [31:0]         s_araddr,
  output logic [31:0]         s_awaddr,
  output logic [31:0]         s_wdata,
  output logic [3:0]          s_wstrb,
  output logic                s_arvalid,
  output logic                s_awvalid,
  output logic                s_wvalid,
  output logic                s_rready,
  output logic                s_bready,
  input  logic                s_arready,
  input  logic                s_awready,
  input  logic                s_wready,
  input  logic                s_rvalid,
  input  logic                s_bvalid,
  input  logic [31:0]         s_rdata,
  output logic [NUM_M-1:0]    grant,
  output logic                busy
);

  localparam int GW = $clog2(NUM_M);

  typedef enum logic [2:0] {
    IDLE,
    RADDR,
    RDATA,
    WADDR,
    WRESP
  } state_t;

  state_t          state_q;
  logic [GW-1:0]   gidx_q;
  logic [NUM_M-1:0] req;
  logic [GW-1:0]   base;
  logic [GW-1:0]   win_d;
  logic            any_d;

  assign req = m_arvalid | (m_awvalid & m_wvalid);

`ifdef AXIL_ARB_FIXED_PRIO_EN
  assign base = '0;
`else
  logic [GW-1:0] rr_ptr_q;
  logic [GW-1:0] rr_ptr_d;
  assign base = rr_ptr_q;
  assign rr_ptr_d = (gidx_q == GW'(NUM_M-1)) ? '0 : gidx_q + 1'b1;
`endif

  // Pick the first requester scanning base, base+1, ... modulo NUM_M.
  always_comb begin : arb
    int j;
    logic [GW-1:0] idx;
    win_d = '0;
    any_d = 1'b0;
    for (int k = NUM_M-1; k >= 0; k--) begin
      j = int'(base) + k;
      if (j >= NUM_M) j = j - NUM_M;
      idx = GW'(j);
      if (req[idx]) begin
        win_d = idx;
        any_d = 1'b1;
      end
    end
  end

  // Transaction FSM; owner and op kind are latched when leaving IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gidx_q   <= '0;
`ifndef AXIL_ARB_FIXED_PRIO_EN
      rr_ptr_q <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_d) begin
            gidx_q  <= win_d;
            state_q <= m_arvalid[win_d] ? RADDR : WADDR;
          end
        end
        RADDR: begin
          if (m_arvalid[gidx_q] & s_arready) state_q <= RDATA;
        end
        RDATA: begin
          if (s_rvalid & m_rready[gidx_q]) begin
            state_q  <= IDLE;
`ifndef AXIL_ARB_FIXED_PRIO_EN
            rr_ptr_q <= rr_ptr_d;
`endif
          end
        end
        WADDR: begin
          if (m_awvalid[gidx_q] & m_wvalid[gidx_q] &
              s_awready & s_wready) state_q <= WRESP;
        end
        WRESP: begin
          if (s_bvalid & m_bready[gidx_q]) begin
            state_q  <= IDLE;
`ifndef AXIL_ARB_FIXED_PRIO_EN
            rr_ptr_q <= rr_ptr_d;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Route only the granted master's channels; everything else stays 0.
  always_comb begin
    m_arready = '0;
    m_awready = '0;
    m_wready  = '0;
    m_rvalid  = '0;
    m_bvalid  = '0;
    m_rdata   = '0;
    s_araddr  = '0;
    s_awaddr  = '0;
    s_wdata   = '0;
    s_wstrb   = '0;
    s_arvalid = 1'b0;
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    s_rready  = 1'b0;
    s_bready  = 1'b0;
    unique case (state_q)
      RADDR: begin
        s_araddr          = m_araddr[int'(gidx_q)*32 +: 32];
        s_arvalid         = m_arvalid[gidx_q];
        m_arready[gidx_q] = s_arready;
      end
      RDATA: begin
        m_rvalid[gidx_q]                 = s_rvalid;
        s_rready                         = m_rready[gidx_q];
        m_rdata[int'(gidx_q)*32 +: 32]   = s_rdata;
      end
      WADDR: begin
        s_awvalid         = m_awvalid[gidx_q] & m_wvalid[gidx_q];
        s_wvalid          = m_awvalid[gidx_q] & m_wvalid[gidx_q];
        s_awaddr          = m_awaddr[int'(gidx_q)*32 +: 32];
        s_wdata           = m_wdata[int'(gidx_q)*32 +: 32];
        s_wstrb           = m_wstrb[int'(gidx_q)*4 +: 4];
        m_awready[gidx_q] = s_awready & s_wready;
        m_wready[gidx_q]  = s_awready & s_wready;
      end
      WRESP: begin
        m_bvalid[gidx_q] = s_bvalid;
        s_bready         = m_bready[gidx_q];
      end
      default: ;
    endcase
  end

  // One-hot owner while a transaction is open.
  always_comb begin
    grant = '0;
    if (state_q != IDLE) grant[gidx_q] = 1'b1;
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_axil_periph_arbiter.sv
// tb_axil_periph_arbiter: cycle-table and directed checks for the AXI-Lite arbiter.
// Bridge responses are driven directly by the bench each cycle.
module tb_axil_periph_arbiter;

  localparam logic [31:0] RD = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst_n;
  logic [63:0] m_araddr, m_awaddr, m_wdata;
  logic [7:0]  m_wstrb;
  logic [1:0]  m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready;
  logic [1:0]  m_arready, m_awready, m_wready, m_rvalid, m_bvalid;
  logic [63:0] m_rdata;
  logic [31:0] s_araddr, s_awaddr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready;
  logic        s_arready, s_awready, s_wready, s_rvalid, s_bvalid;
  logic [31:0] s_rdata;
  logic [1:0]  grant;
  logic        busy;

  int checks = 0;
  int errors = 0;

  axil_periph_arbiter #(.NUM_M(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_araddr(m_araddr), .m_awaddr(m_awaddr),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_arvalid(m_arvalid), .m_awvalid(m_awvalid),
    .m_wvalid(m_wvalid), .m_rready(m_rready),
    .m_bready(m_bready), .m_arready(m_arready),
    .m_awready(m_awready), .m_wready(m_wready),
    .m_rvalid(m_rvalid), .m_bvalid(m_bvalid),
    .m_rdata(m_rdata), .s_araddr(s_araddr),
    .s_awaddr(s_awaddr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_arvalid(s_arvalid),
    .s_awvalid(s_awvalid), .s_wvalid(s_wvalid),
    .s_rready(s_rready), .s_bready(s_bready),
    .s_arready(s_arready), .s_awready(s_awready),
    .s_wready(s_wready), .s_rvalid(s_rvalid),
    .s_bvalid(s_bvalid), .s_rdata(s_rdata),
    .grant(grant), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] arv, awv, wv, rr, br;
    logic       sar, saw, sw, srv, sbv;
  } in_t;

  typedef struct packed {
    logic [1:0]  gnt;
    logic        bsy, sarv, sawv, swv, srr, sbr;
    logic [1:0]  mar, maw, mw, mrv, mbv;
    logic [31:0] sa, wd;
    logic [3:0]  ws;
    logic [31:0] rd0, rd1;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  vec_t tbl[$];

  function automatic in_t mk_i(logic [1:0] arv, awv, wv, rr, br,
                               logic [4:0] sb);
    in_t v;
    v.arv = arv; v.awv = awv; v.wv = wv; v.rr = rr; v.br = br;
    {v.sar, v.saw, v.sw, v.srv, v.sbv} = sb;
    return v;
  endfunction

  // sv = {bsy, sarv, sawv, swv, srr, sbr}
  function automatic out_t mk_o(logic [1:0] g, logic [5:0] sv,
                                logic [1:0] mar, maw, mrv, mbv,
                                logic [31:0] sa, wd, logic [3:0] ws,
                                logic [31:0] rd0, rd1);
    out_t v;
    v.gnt = g;
    {v.bsy, v.sarv, v.sawv, v.swv, v.srr, v.sbr} = sv;
    v.mar = mar; v.maw = maw; v.mw = maw;
    v.mrv = mrv; v.mbv = mbv;
    v.sa = sa; v.wd = wd; v.ws = ws;
    v.rd0 = rd0; v.rd1 = rd1;
    return v;
  endfunction

  task automatic drive(input in_t v);
    m_arvalid = v.arv; m_awvalid = v.awv; m_wvalid = v.wv;
    m_rready = v.rr; m_bready = v.br;
    s_arready = v.sar; s_awready = v.saw; s_wready = v.sw;
    s_rvalid = v.srv; s_bvalid = v.sbv;
  endtask

  function automatic out_t sample();
    out_t a;
    a.gnt = grant; a.bsy = busy;
    a.sarv = s_arvalid; a.sawv = s_awvalid; a.swv = s_wvalid;
    a.srr = s_rready; a.sbr = s_bready;
    a.mar = m_arready; a.maw = m_awready; a.mw = m_wready;
    a.mrv = m_rvalid; a.mbv = m_bvalid;
    a.sa = s_araddr | s_awaddr; a.wd = s_wdata; a.ws = s_wstrb;
    a.rd0 = m_rdata[31:0]; a.rd1 = m_rdata[63:32];
    return a;
  endfunction

  task automatic check(input string name, input out_t exp);
    out_t act;
    act = sample();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic [63:0] got,
                        input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  out_t Z;
  in_t  I0;

  initial begin
    Z  = mk_o(2'b00, 6'b0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0);
    I0 = mk_i(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 5'b0);
    m_araddr = {32'h0000_0208, 32'h0000_0104};
    m_awaddr = {32'h0000_0200, 32'h0000_0300};
    m_wdata  = {32'h0000_00A5, 32'h0000_0011};
    m_wstrb  = {4'hF, 4'h3};
    s_rdata  = RD;

    // simultaneous reads alternate 0,1,0
    for (int r = 0; r < 9; r++)
      tbl.push_back('{mk_i(2'b11, 0, 0, 2'b11, 0, 5'b10010), Z});
    tbl[1].o = mk_o(2'b01, 6'b110000, 2'b01, 0, 0, 0, 32'h104, 0, 0, 0, 0);
    tbl[2].o = mk_o(2'b01, 6'b100010, 0, 0, 2'b01, 0, 0, 0, 0, RD, 0);
    tbl[4].o = mk_o(2'b10, 6'b110000, 2'b10, 0, 0, 0, 32'h208, 0, 0, 0, 0);
    tbl[5].o = mk_o(2'b10, 6'b100010, 0, 0, 2'b10, 0, 0, 0, 0, 0, RD);
    tbl[7].o = mk_o(2'b01, 6'b110000, 2'b01, 0, 0, 0, 32'h104, 0, 0, 0, 0);
    tbl[8].o = mk_o(2'b01, 6'b100010, 0, 0, 2'b01, 0, 0, 0, 0, RD, 0);
    // M1 write: lone awvalid is no request, then w stalls, then resp
    tbl.push_back('{mk_i(0, 2'b10, 0, 0, 2'b10, 5'b01100), Z});
    tbl.push_back('{mk_i(0, 2'b10, 0, 0, 2'b10, 5'b01100), Z});
    tbl.push_back('{mk_i(0, 2'b10, 2'b10, 0, 2'b10, 5'b01000), Z});
    tbl.push_back('{mk_i(0, 2'b10, 2'b10, 0, 2'b10, 5'b01000),
      mk_o(2'b10, 6'b101100, 0, 0, 0, 0, 32'h200, 32'hA5, 4'hF, 0, 0)});
    tbl.push_back('{mk_i(0, 2'b10, 2'b10, 0, 2'b10, 5'b01100),
      mk_o(2'b10, 6'b101100, 0, 2'b10, 0, 0, 32'h200, 32'hA5, 4'hF, 0, 0)});
    tbl.push_back('{mk_i(0, 0, 0, 0, 2'b10, 5'b00000),
      mk_o(2'b10, 6'b100001, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back('{mk_i(0, 0, 0, 0, 2'b10, 5'b00001),
      mk_o(2'b10, 6'b100001, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0)});
    tbl.push_back('{mk_i(0, 0, 0, 0, 2'b10, 5'b00001), Z});
    // M0 read and write pending: read first, one IDLE, then write
    tbl.push_back('{mk_i(2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 5'b11111), Z});
    tbl.push_back('{mk_i(2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 5'b11111),
      mk_o(2'b01, 6'b110000, 2'b01, 0, 0, 0, 32'h104, 0, 0, 0, 0)});
    tbl.push_back('{mk_i(0, 2'b01, 2'b01, 2'b01, 2'b01, 5'b11111),
      mk_o(2'b01, 6'b100010, 0, 0, 2'b01, 0, 0, 0, 0, RD, 0)});
    tbl.push_back('{mk_i(0, 2'b01, 2'b01, 2'b01, 2'b01, 5'b11111), Z});
    tbl.push_back('{mk_i(0, 2'b01, 2'b01, 2'b01, 2'b01, 5'b11111),
      mk_o(2'b01, 6'b101100, 0, 2'b01, 0, 0, 32'h300, 32'h11, 4'h3, 0, 0)});
    tbl.push_back('{mk_i(0, 0, 0, 2'b01, 2'b01, 5'b00001),
      mk_o(2'b01, 6'b100001, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0)});
    tbl.push_back('{I0, Z});

    // reset state with live inputs
    rst_n = 1'b0;
    drive(mk_i(2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 5'b11111));
    @(negedge clk); #1;
    check("reset", Z);
    @(negedge clk);
    drive(I0);
    rst_n = 1'b1;

`ifndef AXIL_ARB_FIXED_PRIO_EN
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].i);
      #1;
      check($sformatf("row%0d", i), tbl[i].o);
    end
`else
    begin
      bit seen;
      @(negedge clk);
      drive(mk_i(2'b11, 0, 0, 2'b11, 0, 5'b10010));
      for (int c = 0; c < 12; c++) begin
        @(negedge clk); #1;
        check1("fp_no_m1", {63'd0, grant == 2'b10}, 64'd0);
      end
      seen = 1'b0;
      for (int c = 0; c < 6 && !seen; c++) begin
        @(negedge clk); #1;
        seen = (grant == 2'b01) && s_rready;
      end
      check1("fp_rdata_seen", {63'd0, seen}, 64'd1);
      drive(mk_i(2'b10, 0, 0, 2'b11, 0, 5'b10010));
      @(negedge clk); #1;
      check1("fp_idle", {62'd0, grant}, 64'd0);
      @(negedge clk); #1;
      check1("fp_m1_gnt", {62'd0, grant}, 64'd2);
    end
`endif

    // reset in RDATA while bridge stalls rvalid
    begin
      bit hit;
      @(negedge clk);
      drive(mk_i(2'b01, 0, 0, 2'b01, 0, 5'b10000));
      hit = 1'b0;
      for (int c = 0; c < 8 && !hit; c++) begin
        @(negedge clk); #1;
        hit = s_rready;
      end
      check1("reach_rdata", {63'd0, hit}, 64'd1);
      rst_n = 1'b0;
      #1;
      check("rst_mid", Z);
      drive(mk_i(2'b01, 0, 0, 2'b01, 0, 5'b10010));
      @(negedge clk); #1;
      check("rst_hold", Z);
      drive(mk_i(2'b10, 0, 0, 2'b10, 0, 5'b10010));
      rst_n = 1'b1;
      hit = 1'b0;
      for (int c = 0; c < 8 && !hit; c++) begin
        @(negedge clk); #1;
        hit = m_rvalid[1];
      end
      check1("post_rst_rvalid", {63'd0, hit}, 64'd1);
      check1("post_rst_rdata", m_rdata, {RD, 32'd0});
      check1("post_rst_grant", {62'd0, grant}, 64'd2);
    end

    @(negedge clk);
    drive(I0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
